// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage cache and IO responder; define DMEM_STATS_EN for hit/miss counters at FFF3/FFF4
module dmem_responder #(
    parameter int          LINES   = 16,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_add,
    input  logic [15:0] mem_wdata,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        io_we,
    input  logic        mem_en,
    output logic [15:0] mem_rdata,
    output logic        stall_cmis,
    output logic        bm_req,
    output logic        bm_we,
    output logic [15:0] bm_addr,
    output logic [15:0] bm_wdata,
    input  logic        bm_ack,
    input  logic [15:0] bm_rdata,
    input  logic [15:0] io_in,
    output logic [15:0] io_out
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RELEASE} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [15:0]        data_mem [LINES];
    logic [15:0]        cyc_cnt;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [15:0]        io_off;
    logic [15:0]        io_rd;
    logic               is_io;
    logic               line_hit;
    logic               load_req;
    logic               store_req;
    logic               start_fill;
    logic               start_write;

`ifdef DMEM_STATS_EN
    logic [15:0]        hit_cnt;
    logic [15:0]        miss_cnt;
`endif

    assign idx         = mem_add[IDX_W-1:0];
    assign tag         = mem_add[15:IDX_W];
    assign fill_idx    = bm_addr[IDX_W-1:0];
    assign fill_tag    = bm_addr[15:IDX_W];
    assign is_io       = (mem_add >= IO_BASE);
    assign io_off      = mem_add - IO_BASE;
    assign line_hit    = valid[idx] && (tag_mem[idx] == tag);
    // A store outranks a load presented in the same cycle
    assign load_req    = mem_re && !mem_we && !is_io;
    assign store_req   = mem_we && !is_io;
    assign start_fill  = (state == IDLE) && load_req && !line_hit;
    assign start_write = (state == IDLE) && store_req;
    assign stall_cmis  = (state == RELEASE) ||
                         ((state == IDLE) && !start_fill && !start_write);

    // IO register read mux; unmapped IO offsets read as zero
    always_comb begin
        io_rd = '0;
        if (is_io) begin
            case (io_off)
                16'd0:   io_rd = io_out;
                16'd1:   io_rd = io_in;
                16'd2:   io_rd = cyc_cnt;
`ifdef DMEM_STATS_EN
                16'd3:   io_rd = hit_cnt;
                16'd4:   io_rd = miss_cnt;
`endif
                default: io_rd = '0;
            endcase
        end
    end

    // Load data only while idle and not stalling; zero otherwise
    always_comb begin
        mem_rdata = '0;
        if ((state == IDLE) && mem_re && !mem_we) begin
            if (is_io)
                mem_rdata = io_rd;
            else if (line_hit)
                mem_rdata = data_mem[idx];
        end
    end

    // Control FSM: backing-memory handshake and line valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= '0;
            bm_req   <= 1'b0;
            bm_we    <= 1'b0;
            bm_addr  <= '0;
            bm_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_write) begin
                        state    <= WRITE;
                        bm_req   <= 1'b1;
                        bm_we    <= 1'b1;
                        bm_addr  <= mem_add;
                        bm_wdata <= mem_wdata;
                    end else if (start_fill) begin
                        state   <= FILL;
                        bm_req  <= 1'b1;
                        bm_we   <= 1'b0;
                        bm_addr <= mem_add;
                    end
                end
                FILL: begin
                    if (bm_ack) begin
                        state           <= IDLE;
                        bm_req          <= 1'b0;
                        valid[fill_idx] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bm_ack) begin
                        state  <= RELEASE;
                        bm_req <= 1'b0;
                        bm_we  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (mem_en)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line tag/data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if ((state == FILL) && bm_ack) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bm_rdata;
        end else if (start_write && line_hit) begin
            data_mem[idx] <= mem_wdata;
        end
    end

    // Output port register and free-running cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_out  <= '0;
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            if (io_we && (mem_add == IO_BASE))
                io_out <= mem_wdata;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating hit/miss counters over cacheable loads seen while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == IDLE) && load_req) begin
            if (line_hit) begin
                if (hit_cnt != 16'hFFFF)
                    hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF)
                    miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized model-checked bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_add = '0;
    logic [15:0] mem_wdata = '0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic        io_we = 1'b0;
    logic        mem_en = 1'b1;
    logic [15:0] mem_rdata;
    logic        stall_cmis;
    logic        bm_req;
    logic        bm_we;
    logic [15:0] bm_addr;
    logic [15:0] bm_wdata;
    logic        bm_ack = 1'b0;
    logic [15:0] bm_rdata = '0;
    logic [15:0] io_in = '0;
    logic [15:0] io_out;

    dmem_responder dut (
        .clk(clk), .rst(rst), .mem_add(mem_add), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .io_we(io_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata), .stall_cmis(stall_cmis), .bm_req(bm_req),
        .bm_we(bm_we), .bm_addr(bm_addr), .bm_wdata(bm_wdata), .bm_ack(bm_ack),
        .bm_rdata(bm_rdata), .io_in(io_in), .io_out(io_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: backing store, which address each line holds, IO state
    logic [15:0] bmem [0:65535];
    bit          mv [16];
    logic [15:0] maddr [16];
    logic [15:0] m_io_out = '0;
    logic [15:0] m_cyc;
    int          m_hits = 0;
    int          m_miss = 0;
    bit          cmp_en = 1'b0;
    bit          resp_en = 1'b1;
    int          lat_force = 0;
    logic [15:0] last_req_addr;
    logic [15:0] last_wdata;
    logic        last_we;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        if (a >= 16'hFFF0) begin
            case (a)
                16'hFFF0: return m_io_out;
                16'hFFF1: return io_in;
                16'hFFF2: return m_cyc;
`ifdef DMEM_STATS_EN
                16'hFFF3: return sat16(m_hits);
                16'hFFF4: return sat16(m_miss);
`endif
                default:  return 16'h0000;
            endcase
        end
        return bmem[a];
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return mv[a[3:0]] && (maddr[a[3:0]] == a);
    endfunction

    // Cycle counter reference: counts rising edges since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) m_cyc <= '0;
        else      m_cyc <= m_cyc + 16'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        m_io_out = '0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // Backing memory: acknowledges each request after 1..4 cycles
    initial begin
        int l;
        forever begin
            @(negedge clk);
            if (resp_en && rst && bm_req) begin
                l = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
                repeat (l) @(posedge clk);
                #1;
                if (bm_we) bmem[bm_addr] = bm_wdata;
                else       bm_rdata = bmem[bm_addr];
                bm_ack = 1'b1;
                @(posedge clk);
                #1;
                bm_ack = 1'b0;
                bm_rdata = 16'($urandom);
            end
        end
    end

    // Per-cycle comparison of outputs against the model
    always @(negedge clk) begin
        if (rst && cmp_en) begin
            chk("io_out", io_out, m_io_out);
            if (!stall_cmis || !mem_re)
                chk("rdata_zero", mem_rdata, 16'h0000);
            else if (!mem_we)
                chk("rdata", mem_rdata, exp_read(mem_add));
            if (bm_req) begin
                chk("bm_addr", bm_addr, mem_add);
                chk("bm_we", 16'(bm_we), 16'(mem_we));
                if (bm_we) chk("bm_wdata", bm_wdata, mem_wdata);
            end
        end
    end

    task automatic do_reset;
        cmp_en = 1'b0;
        rst = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0; io_we = 1'b0; mem_en = 1'b1;
        model_reset();
        #1;
        chk("rst_bm_req", 16'(bm_req), 16'h0);
        chk("rst_bm_we", 16'(bm_we), 16'h0);
        chk("rst_bm_addr", bm_addr, 16'h0);
        chk("rst_bm_wdata", bm_wdata, 16'h0);
        chk("rst_io_out", io_out, 16'h0);
        chk("rst_stall", 16'(stall_cmis), 16'h1);
        tick(); tick();
        rst = 1'b1;
        cmp_en = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] a, output bit missed, output logic [15:0] d);
        bit hit;
        int n;
        hit = model_hit(a);
        mem_add = a; mem_re = 1'b1; mem_we = 1'b0;
        @(negedge clk);
        missed = !stall_cmis;
        chk("load_stall", 16'(stall_cmis), 16'(hit));
        if (!stall_cmis) begin
            n = 0;
            do begin
                tick();
                if (n == 0) m_miss++;
                @(negedge clk);
                if (n == 0) begin
                    last_req_addr = bm_addr;
                    chk("fill_req", 16'(bm_req), 16'h1);
                end
                n++;
            end while (!stall_cmis && n < 40);
            chk("fill_done", 16'(stall_cmis), 16'h1);
            mv[a[3:0]] = 1'b1;
            maddr[a[3:0]] = a;
        end
        chk("load_noreq", 16'(bm_req), 16'h0);
        d = mem_rdata;
        tick();
        m_hits++;
        mem_re = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] w, input int hold);
        int n;
        mem_add = a; mem_wdata = w; mem_we = 1'b1; mem_re = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        chk("st_stall0", 16'(stall_cmis), 16'h0);
        n = 0;
        do begin
            tick();
            @(negedge clk);
            if (n == 0) begin
                last_we = bm_we;
                last_wdata = bm_wdata;
                chk("st_req", 16'(bm_req), 16'h1);
            end
            n++;
        end while (!stall_cmis && n < 40);
        chk("st_done", 16'(stall_cmis), 16'h1);
        chk("st_req_drop", 16'(bm_req), 16'h0);
        for (int i = 0; i < hold; i++) begin
            tick();
            @(negedge clk);
            chk("rel_hold", 16'(stall_cmis), 16'h1);
        end
        tick();
        mem_en = 1'b1;
        @(negedge clk);
        chk("rel_stall", 16'(stall_cmis), 16'h1);
        tick();
        mem_we = 1'b0;
    endtask

    task automatic do_io_write(input logic [15:0] a, input logic [15:0] w);
        mem_add = a; mem_wdata = w; io_we = 1'b1;
        @(negedge clk);
        chk("iow_stall", 16'(stall_cmis), 16'h1);
        tick();
        io_we = 1'b0;
        if (a == 16'hFFF0) m_io_out = w;
    endtask

    task automatic do_io_read(input logic [15:0] a, output logic [15:0] d);
        mem_add = a; mem_re = 1'b1;
        @(negedge clk);
        chk("ior_stall", 16'(stall_cmis), 16'h1);
        d = mem_rdata;
        tick();
        mem_re = 1'b0;
    endtask

    task automatic do_io_store(input logic [15:0] a, input logic [15:0] w);
        mem_add = a; mem_wdata = w; mem_we = 1'b1;
        @(negedge clk);
        chk("ios_stall", 16'(stall_cmis), 16'h1);
        tick();
        mem_we = 1'b0;
        @(negedge clk);
        chk("ios_noreq", 16'(bm_req), 16'h0);
        tick();
    endtask

    initial begin
        bit          missed;
        logic [15:0] d;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) bmem[i] = 16'($urandom);
        bmem[16'h0010] = 16'hBEEF;

        do_reset();
        do_io_read(16'hFFF2, d);
        chk("cyc_first", d, 16'h0000);

        // Miss then hit on 0010
        lat_force = 3;
        do_load(16'h0010, missed, d);
        chk("t1_missed", 16'(missed), 16'h1);
        chk("t1_addr", last_req_addr, 16'h0010);
        chk("t1_data", d, 16'hBEEF);
        do_load(16'h0010, missed, d);
        chk("t1_rehit", 16'(missed), 16'h0);
        chk("t1_redata", d, 16'hBEEF);
        lat_force = 0;

        // Conflict on the same index evicts the earlier line
        do_load(16'h0020, missed, d);
        chk("t2_conflict", 16'(missed), 16'h1);
        do_load(16'h0010, missed, d);
        chk("t2_evicted", 16'(missed), 16'h1);

        // Write-through to a cached line
        do_store(16'h0010, 16'h1234, 0);
        chk("t3_we", 16'(last_we), 16'h1);
        chk("t3_wdata", last_wdata, 16'h1234);
        do_load(16'h0010, missed, d);
        chk("t3_hit", 16'(missed), 16'h0);
        chk("t3_data", d, 16'h1234);

        // IO registers
        do_io_write(16'hFFF0, 16'h00A5);
        chk("t4_io_out", io_out, 16'h00A5);
        io_in = 16'h5A3C;
        do_io_read(16'hFFF1, d);
        chk("t4_io_in", d, 16'h5A3C);
        do_io_read(16'hFFF0, d);
        chk("t4_io_rb", d, 16'h00A5);

        // Reset during a refill
        resp_en = 1'b0;
        mem_add = 16'h0050; mem_re = 1'b1;
        @(negedge clk);
        chk("t5_stall0", 16'(stall_cmis), 16'h0);
        tick();
        @(negedge clk);
        chk("t5_req", 16'(bm_req), 16'h1);
        #2;
        cmp_en = 1'b0;
        rst = 1'b0;
        mem_re = 1'b0;
        model_reset();
        #1;
        chk("t5_req_drop", 16'(bm_req), 16'h0);
        chk("t5_stall1", 16'(stall_cmis), 16'h1);
        tick();
        rst = 1'b1;
        cmp_en = 1'b1;
        bm_rdata = 16'h1111; bm_ack = 1'b1;
        tick();
        bm_ack = 1'b0;
        @(negedge clk);
        chk("t5_late_ack", 16'(bm_req), 16'h0);
        chk("t5_late_stall", 16'(stall_cmis), 16'h1);
        tick();
        resp_en = 1'b1;
        do_load(16'h0050, missed, d);
        chk("t5_invalid", 16'(missed), 16'h1);

        // Statistics counters
        do_reset();
        do_load(16'h0030, missed, d);
        do_load(16'h0030, missed, d);
        do_io_read(16'hFFF4, d);
`ifdef DMEM_STATS_EN
        chk("t6_miss", d, 16'h0001);
`else
        chk("t6_miss", d, 16'h0000);
`endif
        do_io_read(16'hFFF3, d);
`ifdef DMEM_STATS_EN
        chk("t6_hit", d, 16'h0002);
`else
        chk("t6_hit", d, 16'h0000);
`endif

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            io_in = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_load(16'($urandom_range(0, 63)), missed, d);
                4, 5:       do_store(16'($urandom_range(0, 63)), 16'($urandom),
                                     int'($urandom_range(0, 2)));
                6: begin
                    case ($urandom_range(0, 3))
                        0, 1:    a = 16'hFFF0;
                        2:       a = 16'hFFF0 + 16'($urandom_range(1, 15));
                        default: a = 16'($urandom_range(0, 63));
                    endcase
                    do_io_write(a, 16'($urandom));
                end
                7: do_io_read(16'hFFF0 + 16'($urandom_range(0, 7)), d);
                8: do_io_store(16'hFFF0 + 16'($urandom_range(0, 15)), 16'($urandom));
                default: tick();
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
